// File: rtl/seg_display_arbiter.sv
// Nexys3 4-digit seven-segment scan with A/B source arbitration.
// Background A is shown continuously; B overlays it for a timed hold.
module seg_display_arbiter #(
  parameter int SCAN_DIV   = 50000,
  parameter int HOLD_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_val,
  input  logic        b_req,
  input  logic [15:0] b_val,
  output logic        b_ack,
  output logic        src,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PMAX  = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HLOAD = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HONE  = HW'(1);

  typedef enum logic {
    SHOW_A,
    SHOW_B
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic          capture;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   frame, hold_reg;
  logic [15:0]   frame_ld, digit_src;
  logic [3:0]    nib;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign tick    = (pcnt == PMAX);
  assign capture = b_req & ~b_ack;
  assign idx_nx  = idx + 2'd1;
  assign src     = (state_q == SHOW_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // A new capture always wins over an expiring hold.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      SHOW_A: begin
        if (capture) begin
          state_d = SHOW_B;
          hcnt_d  = HLOAD;
        end
      end
      SHOW_B: begin
        if (capture) begin
          hcnt_d = HLOAD;
        end else if (tick) begin
          hcnt_d = hcnt_q - HONE;
          if (hcnt_q == HONE) begin
            state_d = SHOW_A;
          end
        end
      end
      default: state_d = SHOW_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW_A;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign frame_ld  = src ? hold_reg : a_val;
  assign digit_src = (idx_nx == 2'd0) ? frame_ld : frame;

  always_comb begin
    nib = digit_src[3:0];
    unique case (idx_nx)
      2'd0: nib = digit_src[3:0];
      2'd1: nib = digit_src[7:4];
      2'd2: nib = digit_src[11:8];
      2'd3: nib = digit_src[15:12];
      default: nib = digit_src[3:0];
    endcase
  end

  // Frame is latched only at digit 0 so one scan never mixes values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 2'd3;
      frame    <= '0;
      hold_reg <= '0;
      b_ack    <= 1'b0;
      an       <= 4'b1111;
      seg      <= 8'hFF;
    end else begin
      b_ack <= capture;
      if (capture) begin
        hold_reg <= b_val;
      end
      if (tick) begin
        idx <= idx_nx;
        an  <= ~(4'b0001 << idx_nx);
        seg <= hex7(nib);
        if (idx_nx == 2'd0) begin
          frame <= frame_ld;
        end
      end
    end
  end

endmodule
